// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection.
//
// Registers the control decoder outputs together with the ID-stage operands
// and instruction fields, and presents them to EX one cycle later. It also
// produces the stall that freezes PC and IF/ID, inserts bubbles on load-use
// hazards, squashes on flush, and counts bubbles and flushes.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             squash the ID instruction (bubble into EX)
//   ext_hold          freeze the whole register (multi-cycle memory stall)
//   id_*              decoder controls, operands and fields from ID
//   ex_*              registered copies presented to EX
//   stall             combinational; hold PC and IF/ID this cycle
//   bubble_cnt        load-use bubbles inserted (wraps)
//   flush_cnt         flushes taken (wraps)
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ext_hold,
    input  logic             id_valid,
    input  logic             id_jump,
    input  logic             id_RegDst,
    input  logic             id_Branch,
    input  logic             id_MemR,
    input  logic             id_Mem2R,
    input  logic             id_MemW,
    input  logic             id_RegW,
    input  logic             id_Alusrc,
    input  logic [1:0]       id_ExtOp,
    input  logic [4:0]       id_Aluctrl,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    output logic             ex_valid,
    output logic             ex_jump,
    output logic             ex_RegDst,
    output logic             ex_Branch,
    output logic             ex_MemR,
    output logic             ex_Mem2R,
    output logic             ex_MemW,
    output logic             ex_RegW,
    output logic             ex_Alusrc,
    output logic [1:0]       ex_ExtOp,
    output logic [4:0]       ex_Aluctrl,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Every field travels as one flat word so a bubble is simply all-zero
    // and a load is a single copy; the field order is identical on both sides.
    localparam int BUNDLE_W = 9 + 2 + 5 + 4 * 32 + 4 * 5;

    logic [BUNDLE_W-1:0] id_bundle;
    logic [BUNDLE_W-1:0] ex_q;
    logic                lu;

    assign id_bundle = {id_valid, id_jump, id_RegDst, id_Branch, id_MemR,
                        id_Mem2R, id_MemW, id_RegW, id_Alusrc, id_ExtOp,
                        id_Aluctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
                        id_rs, id_rt, id_rd, id_shamt};

    assign {ex_valid, ex_jump, ex_RegDst, ex_Branch, ex_MemR,
            ex_Mem2R, ex_MemW, ex_RegW, ex_Alusrc, ex_ExtOp,
            ex_Aluctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
            ex_rs, ex_rt, ex_rd, ex_shamt} = ex_q;

    // A load in EX whose destination is read by the ID instruction.
    // Register 0 is hardwired, so it can never carry a dependency.
    assign lu = ex_valid & ex_MemR & (ex_rt != 5'd0) & id_valid &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

    // A flush discards the ID instruction, so its hazard no longer matters;
    // an external hold always freezes the front end.
    assign stall = (lu & ~flush) | ext_hold;

    // Update priority: reset, flush, hold, load-use bubble, normal load.
    // A hazard seen while held is re-evaluated once the hold releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            ex_q      <= '0;
            flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (ext_hold) begin
            ex_q <= ex_q;
        end else if (lu) begin
            ex_q       <= '0;
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else begin
            ex_q <= id_bundle;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed bench for id_ex_stage. Stimulus pushes the expected EX contents
// and counter values into a scoreboard queue; a monitor pops one entry after
// each rising edge and compares. stall is checked in the same cycle it is
// driven, since it is combinational.
module tb_id_ex_stage;

    localparam int W = 164;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ext_hold;
    logic        id_valid, id_jump, id_RegDst, id_Branch, id_MemR;
    logic        id_Mem2R, id_MemW, id_RegW, id_Alusrc;
    logic [1:0]  id_ExtOp;
    logic [4:0]  id_Aluctrl;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        ex_valid, ex_jump, ex_RegDst, ex_Branch, ex_MemR;
    logic        ex_Mem2R, ex_MemW, ex_RegW, ex_Alusrc;
    logic [1:0]  ex_ExtOp;
    logic [4:0]  ex_Aluctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic        stall;
    logic [3:0]  bubble_cnt, flush_cnt;

    typedef struct {
        string      name;
        logic [W-1:0] ex;
        logic [3:0] bcnt;
        logic [3:0] fcnt;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] held;

    id_ex_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ext_hold(ext_hold),
        .id_valid(id_valid), .id_jump(id_jump), .id_RegDst(id_RegDst),
        .id_Branch(id_Branch), .id_MemR(id_MemR), .id_Mem2R(id_Mem2R),
        .id_MemW(id_MemW), .id_RegW(id_RegW), .id_Alusrc(id_Alusrc),
        .id_ExtOp(id_ExtOp), .id_Aluctrl(id_Aluctrl), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_RegDst(ex_RegDst),
        .ex_Branch(ex_Branch), .ex_MemR(ex_MemR), .ex_Mem2R(ex_Mem2R),
        .ex_MemW(ex_MemW), .ex_RegW(ex_RegW), .ex_Alusrc(ex_Alusrc),
        .ex_ExtOp(ex_ExtOp), .ex_Aluctrl(ex_Aluctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .stall(stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard in case something stops the stimulus from finishing.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // The bench's own ID inputs, flattened in the order EX presents them.
    function automatic logic [W-1:0] idBundle();
        return {id_valid, id_jump, id_RegDst, id_Branch, id_MemR,
                id_Mem2R, id_MemW, id_RegW, id_Alusrc, id_ExtOp,
                id_Aluctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
                id_rs, id_rt, id_rd, id_shamt};
    endfunction

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearId();
        {id_valid, id_jump, id_RegDst, id_Branch, id_MemR} = '0;
        {id_Mem2R, id_MemW, id_RegW, id_Alusrc} = '0;
        id_ExtOp = '0; id_Aluctrl = '0;
        id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
    endtask

    task automatic randomizeId();
        {id_valid, id_jump, id_RegDst, id_Branch, id_MemR} = 5'($urandom);
        {id_Mem2R, id_MemW, id_RegW, id_Alusrc} = 4'($urandom);
        id_ExtOp = 2'($urandom); id_Aluctrl = 5'($urandom);
        id_pc4 = $urandom; id_rs_data = $urandom;
        id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_rd = 5'($urandom); id_shamt = 5'($urandom);
    endtask

    // A lw rt, imm(rs) as the decoder would present it.
    task automatic setLw(input logic [4:0] rs, input logic [4:0] rt);
        clearId();
        id_valid = 1'b1; id_MemR = 1'b1; id_Mem2R = 1'b1; id_RegW = 1'b1;
        id_Alusrc = 1'b1; id_ExtOp = 2'b01; id_Aluctrl = 5'h02;
        id_rs = rs; id_rt = rt;
        id_rs_data = 32'h1000_0000; id_imm = 32'h0000_0004;
        id_pc4 = 32'h0040_0010;
    endtask

    // An R-type add rd, rs, rt.
    task automatic setAluOp(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd);
        clearId();
        id_valid = 1'b1; id_RegDst = 1'b1; id_RegW = 1'b1;
        id_Aluctrl = 5'h02;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = 32'hA5A5_0001; id_rt_data = 32'h0000_0003;
        id_pc4 = 32'h0040_0014;
    endtask

    // Called just after a falling edge with the inputs already set: checks
    // the combinational stall, queues what EX must show after the next
    // rising edge, then waits for the following falling edge.
    task automatic applyStimulus(input string name, input logic [W-1:0] expEx,
                                 input logic [3:0] expB, input logic [3:0] expF,
                                 input logic expStall, input bit chkStall);
        exp_t e;
        #1;
        if (chkStall) checkOutput({name, "_stall"}, W'(stall), W'(expStall));
        e.name = name; e.ex = expEx; e.bcnt = expB; e.fcnt = expF;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, compare EX and the counters with the
    // oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, "_ex"},
                        {ex_valid, ex_jump, ex_RegDst, ex_Branch, ex_MemR,
                         ex_Mem2R, ex_MemW, ex_RegW, ex_Alusrc, ex_ExtOp,
                         ex_Aluctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                         ex_rs, ex_rt, ex_rd, ex_shamt}, e.ex);
            checkOutput({e.name, "_bubble_cnt"}, W'(bubble_cnt), W'(e.bcnt));
            checkOutput({e.name, "_flush_cnt"}, W'(flush_cnt), W'(e.fcnt));
        end
    end

    // Directed sequence; each step's expected values are worked out by hand.
    initial begin
        rst = 1'b1; flush = 1'b0; ext_hold = 1'b0;
        randomizeId();
        applyStimulus("reset0", '0, 4'd0, 4'd0, 1'b0, 0);
        randomizeId();
        ext_hold = 1'b1;
        applyStimulus("reset1_hold", '0, 4'd0, 4'd0, 1'b1, 1);
        rst = 1'b0; ext_hold = 1'b0;

        clearId();
        id_Aluctrl = 5'h02; id_RegW = 1'b1; id_rs_data = 32'h1234_5678;
        id_rd = 5'd9; id_valid = 1'b1;
        applyStimulus("pass", idBundle(), 4'd0, 4'd0, 1'b0, 1);

        // lw then a dependent add: one bubble, add enters two cycles later
        setLw(5'd2, 5'd8);
        applyStimulus("lw_load", idBundle(), 4'd0, 4'd0, 1'b0, 1);
        setAluOp(5'd8, 5'd5, 5'd10);
        applyStimulus("lu_bubble", '0, 4'd1, 4'd0, 1'b1, 1);
        applyStimulus("lu_reload", idBundle(), 4'd1, 4'd0, 1'b0, 1);

        // Register zero and no-dependency cases
        setLw(5'd1, 5'd0);
        applyStimulus("lw_r0_load", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setAluOp(5'd0, 5'd0, 5'd11);
        applyStimulus("r0_nohaz", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setLw(5'd1, 5'd8);
        applyStimulus("lw8_load", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setAluOp(5'd3, 5'd4, 5'd12);
        applyStimulus("nodep", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setAluOp(5'd1, 5'd8, 5'd13);
        applyStimulus("alu_rt8_load", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setAluOp(5'd8, 5'd2, 5'd14);
        applyStimulus("nomemr", idBundle(), 4'd1, 4'd0, 1'b0, 1);

        // An invalid ID slot never stalls and loads with ex_valid low
        setLw(5'd1, 5'd8);
        applyStimulus("lw8_load2", idBundle(), 4'd1, 4'd0, 1'b0, 1);
        setAluOp(5'd8, 5'd8, 5'd15);
        id_valid = 1'b0;
        applyStimulus("invalid_id", idBundle(), 4'd1, 4'd0, 1'b0, 1);

        // Reset in the middle of traffic
        rst = 1'b1;
        setAluOp(5'd1, 5'd2, 5'd3);
        applyStimulus("mid_reset", '0, 4'd0, 4'd0, 1'b0, 1);
        rst = 1'b0;

        // Flush beats a pending hazard (rt-side match)
        setLw(5'd2, 5'd8);
        applyStimulus("lw8_pre_flush", idBundle(), 4'd0, 4'd0, 1'b0, 1);
        setAluOp(5'd5, 5'd8, 5'd16);
        #1;
        checkOutput("rt_match_stall", W'(stall), W'(1'b1));
        flush = 1'b1;
        applyStimulus("flush_lu", '0, 4'd0, 4'd1, 1'b0, 1);
        flush = 1'b0;

        // Hold freezes EX even with a hazard pending; bubble comes after
        setLw(5'd2, 5'd8);
        held = idBundle();
        applyStimulus("lw8_pre_hold", held, 4'd0, 4'd1, 1'b0, 1);
        setAluOp(5'd8, 5'd1, 5'd17);
        ext_hold = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus("hold", held, 4'd0, 4'd1, 1'b1, 1);
        ext_hold = 1'b0;
        applyStimulus("lu_after_hold", '0, 4'd1, 4'd1, 1'b1, 1);

        // Flush together with hold: register clears, stall still up
        flush = 1'b1; ext_hold = 1'b1;
        applyStimulus("flush_hold", '0, 4'd1, 4'd2, 1'b1, 1);
        flush = 1'b0; ext_hold = 1'b0;

        // Sixteen flushes from zero bring the 4-bit counter back to zero
        rst = 1'b1;
        applyStimulus("reset_wrap", '0, 4'd0, 4'd0, 1'b0, 1);
        rst = 1'b0;
        flush = 1'b1;
        for (int i = 1; i <= 16; i++)
            applyStimulus("wrap", '0, 4'd0, 4'(i), 1'b0, 1);
        flush = 1'b0;
        setAluOp(5'd1, 5'd2, 5'd3);
        applyStimulus("post_wrap", idBundle(), 4'd0, 4'd0, 1'b0, 1);

        // Let the monitor drain the queue within a few cycles
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("drain", W'(sb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
